starfield_layer_scheduler: RTL

//  Multi-layer (parallax) starfield controller. Shares one external LFSR between NUM_LAYERS star layers.

---
 rtl/starfield_layer_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/starfield_layer_scheduler.sv
// Parallax starfield controller: several star layers count down random pixel gaps and
// share one external LFSR through a round-robin arbiter that grants one reload per cycle.
module starfield_layer_scheduler #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int NUM_LAYERS = 3,
    parameter int GAP_W      = 10,
    parameter int MIN_GAP    = 1,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XW-1:0]         pxl_x,
    input  logic [YW-1:0]         pxl_y,
    input  logic [NUM_LAYERS-1:0] layer_en,
    input  logic [GAP_W-1:0]      lfsr_val,
    output logic                  lfsr_en,
    output logic                  lfsr_init,
    output logic [NUM_LAYERS-1:0] star_draw,
    output logic [LW-1:0]         star_layer,
    output logic                  Draw,
    output logic [3:0]            Red,
    output logic [3:0]            Green,
    output logic [3:0]            Blue
);
    localparam int CW = GAP_W + 1;

    typedef enum logic [1:0] {G_IDLE, G_INIT, G_RUN} gstate_t;
    typedef enum logic [1:0] {L_WAIT, L_FIRE, L_PEND} lstate_t;

    gstate_t               state_q;
    logic [LW-1:0]         rr_q;
    logic                  lfsr_init_q;
    logic [NUM_LAYERS-1:0] star_draw_q;
    logic [LW-1:0]         star_layer_q;
    logic                  draw_q;
    logic [3:0]            grey_q;

    logic                  frame_start;
    logic                  run_active;
    logic [NUM_LAYERS-1:0] pend_vec;
    logic [NUM_LAYERS-1:0] fire_vec;
    logic                  gnt_valid;
    logic [LW-1:0]         gnt_idx;
    logic [LW-1:0]         layer_d;
    logic [3:0]            grey_d;

    assign frame_start = (pxl_x == '0) && (pxl_y == '0);
    // A frame-start pixel in RUN freezes layers and arbitration for that cycle.
    assign run_active  = !reset && (state_q == G_RUN) && !frame_start;

    always_comb begin
        logic [LW-1:0] cand;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            cand = LW'((int'(rr_q) + i) % NUM_LAYERS);
            if (run_active && !gnt_valid && pend_vec[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
            lstate_t       st_q;
            logic [CW-1:0] cnt_q;
            logic          granted;

            assign granted      = gnt_valid && (gnt_idx == LW'(gi));
            assign pend_vec[gi] = (st_q == L_PEND) && layer_en[gi];
            assign fire_vec[gi] = (st_q == L_FIRE) && layer_en[gi] && run_active;

            // WAIT with cnt 0 is the parked state; in RUN it re-requests a gap.
            always_ff @(posedge clk) begin
                if (reset || !layer_en[gi]) begin
                    st_q  <= L_WAIT;
                    cnt_q <= '0;
                end else if (state_q == G_INIT) begin
                    st_q  <= L_PEND;
                    cnt_q <= '0;
                end else if (run_active) begin
                    case (st_q)
                        L_WAIT: begin
                            if (cnt_q > CW'(1)) begin
                                cnt_q <= cnt_q - CW'(1);
                            end else if (cnt_q == CW'(1)) begin
                                cnt_q <= '0;
                                st_q  <= L_FIRE;
                            end else begin
                                st_q  <= L_PEND;
                            end
                        end
                        L_FIRE: st_q <= L_PEND;
                        L_PEND: begin
                            if (granted) begin
                                cnt_q <= {1'b0, lfsr_val} + CW'(MIN_GAP);
                                st_q  <= L_WAIT;
                            end
                        end
                        default: st_q <= L_WAIT;
                    endcase
                end
            end
        end
    endgenerate

    always_comb begin
        layer_d = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (fire_vec[i]) layer_d = LW'(i);
        end
    end

    assign grey_d = (|fire_vec) ? (4'hF >> layer_d) : 4'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= G_IDLE;
            rr_q         <= '0;
            lfsr_init_q  <= 1'b0;
            star_draw_q  <= '0;
            star_layer_q <= '0;
            draw_q       <= 1'b0;
            grey_q       <= '0;
        end else begin
            lfsr_init_q <= 1'b0;
            case (state_q)
                G_IDLE: begin
                    if (frame_start) begin
                        state_q     <= G_INIT;
                        lfsr_init_q <= 1'b1;
                    end
                end
                G_INIT: state_q <= G_RUN;
                G_RUN: begin
                    if (frame_start) begin
                        state_q     <= G_INIT;
                        lfsr_init_q <= 1'b1;
                    end else if (gnt_valid) begin
                        rr_q <= (gnt_idx == LW'(NUM_LAYERS - 1)) ? '0 : gnt_idx + LW'(1);
                    end
                end
                default: state_q <= G_IDLE;
            endcase
            star_draw_q  <= fire_vec;
            star_layer_q <= layer_d;
            draw_q       <= |fire_vec;
            grey_q       <= grey_d;
        end
    end

    assign lfsr_en    = gnt_valid;
    assign lfsr_init  = lfsr_init_q;
    assign star_draw  = star_draw_q;
    assign star_layer = star_layer_q;
    assign Draw       = draw_q;
    assign Red        = grey_q;
    assign Green      = grey_q;
    assign Blue       = grey_q;
endmodule
